pwm_capture: RTL and testbench

//   Receive side of the PWM path: measures an incoming PWM waveform and reports high time and period
//   in clk cycles. One report is produced per rising-edge-to-rising-edge interval.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_sync_edge.sv | 29 ++
 rtl/pwm_capture.sv | 146 ++++++++++++++
 tb/tb_pwm_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM receive path: capture FSM states and default sizing.
package pwm_pkg;

    localparam int R_SIZE_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes an asynchronous single-bit input and flags its rising/falling edges.
// Reusable for any slow asynchronous level signal; STAGES must be at least 2.
module pwm_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            s_d   <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~s_d;
    assign fall = ~chain[STAGES-1] & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM signal, one report per rise-to-rise interval.
// Optional stuck-line detection is enabled by defining PWM_CAPTURE_TIMEOUT_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int R_SIZE      = R_SIZE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [R_SIZE-1:0] high_cnt,
    output logic [R_SIZE-1:0] period,
    output logic              valid,
    output logic              ovf,
    output logic              timeout
);

    localparam logic [R_SIZE-1:0] CNT_MAX  = '1;
    localparam logic [R_SIZE-1:0] CNT_NEAR = CNT_MAX - R_SIZE'(1);

    logic              rise;
    logic              fall;
    logic [R_SIZE-1:0] cnt;
    logic [R_SIZE-1:0] hi_latch;
    logic              sat;
    logic              load_hi;
    logic              report;
    state_t            state;
    state_t            next_state;

    pwm_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (pwm_in),
        .rise(rise),
        .fall(fall)
    );

    // Free-running cycle counter restarted by every rise; it parks at all-ones so long gaps read as saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (rise) begin
            cnt <= R_SIZE'(1);
            sat <= 1'b0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + R_SIZE'(1);
            if (cnt == CNT_NEAR) begin
                sat <= 1'b1;
            end
        end
    end

`ifdef PWM_CAPTURE_TIMEOUT_EN
    logic sat_set;
    logic tmo;
    logic tmo_stuck_high;
    logic timeout_q;

    assign sat_set = ~rise & (cnt == CNT_NEAR);
`endif

    always_comb begin
        next_state = state;
        load_hi    = 1'b0;
        report     = 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
        tmo            = 1'b0;
        tmo_stuck_high = 1'b0;
`endif
        case (state)
            IDLE: if (rise) next_state = HIGH;
            HIGH: if (fall) begin
                load_hi    = 1'b1;
                next_state = LOW;
            end
            LOW: if (rise) begin
                report     = 1'b1;
                next_state = HIGH;
            end
            default: next_state = IDLE;
        endcase
`ifdef PWM_CAPTURE_TIMEOUT_EN
        // Judge the stuck level by where the FSM is heading, so a fall on the same cycle counts as stuck low.
        if (sat_set && next_state != IDLE) begin
            tmo            = 1'b1;
            tmo_stuck_high = (next_state == HIGH);
            report         = 1'b0;
            next_state     = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hi_latch <= '0;
        end else begin
            state <= next_state;
            if (load_hi) begin
                hi_latch <= cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt <= '0;
            period   <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
            timeout_q <= 1'b0;
            if (tmo) begin
                high_cnt  <= tmo_stuck_high ? CNT_MAX : '0;
                period    <= CNT_MAX;
                ovf       <= 1'b1;
                valid     <= 1'b1;
                timeout_q <= 1'b1;
            end
`endif
            if (report) begin
                high_cnt <= hi_latch;
                period   <= cnt;
                ovf      <= sat;
                valid    <= 1'b1;
            end
        end
    end

`ifdef PWM_CAPTURE_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Drives pwm_capture (8-bit and 9-bit builds) with waveforms and checks reports against a timeline model.
module tb_pwm_capture;

    typedef struct {
        int hi;
        int per;
        int ovf;
        int to;
        int t;
    } rep_t;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] high_cnt8, period8;
    logic       valid8, ovf8, timeout8;
    logic [8:0] high_cnt9, period9;
    logic       valid9, ovf9, timeout9;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   seg_lv[$];
    int   seg_dur[$];
    rep_t obs8[$];
    rep_t obs9[$];

    pwm_capture #(.R_SIZE(8), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .high_cnt(high_cnt8), .period(period8), .valid(valid8), .ovf(ovf8), .timeout(timeout8)
    );

    pwm_capture #(.R_SIZE(9), .SYNC_STAGES(SYNC)) dut9 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .high_cnt(high_cnt9), .period(period9), .valid(valid9), .ovf(ovf9), .timeout(timeout9)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rep_t x;
        if (valid8) begin
            x.hi = int'(high_cnt8); x.per = int'(period8); x.ovf = int'(ovf8);
            x.to = int'(timeout8);  x.t = cyc;
            obs8.push_back(x);
        end
        if (valid9) begin
            x.hi = int'(high_cnt9); x.per = int'(period9); x.ovf = int'(ovf9);
            x.to = int'(timeout9);  x.t = cyc;
            obs9.push_back(x);
        end
    end

    task automatic check_output(input string tag, input int got, input int want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic add_seg(input int lv, input int dur);
        seg_lv.push_back(lv);
        seg_dur.push_back(dur);
    endtask

    // Walks the pin timeline: reports land one cycle after each closing rise, timeouts when a phase reaches mx.
    task automatic build_model(input int mx, output rep_t e[$]);
        int   prev  = 0;
        int   t     = 0;
        int   phase = 0;
        int   r     = 0;
        int   h     = 0;
        rep_t x;
        e = {};
        for (int i = 0; i <= seg_lv.size(); i++) begin
`ifdef PWM_CAPTURE_TIMEOUT_EN
            if (phase != 0 && t - r >= mx) begin
                x.hi = (phase == 1) ? mx : 0; x.per = mx; x.ovf = 1; x.to = 1; x.t = r + mx;
                e.push_back(x);
                phase = 0;
            end
`endif
            if (i == seg_lv.size()) break;
            if (seg_lv[i] != prev) begin
                if (seg_lv[i] == 1) begin
                    if (phase == 2) begin
                        x.hi = h; x.per = (t - r < mx) ? t - r : mx; x.ovf = (t - r >= mx) ? 1 : 0;
                        x.to = 0; x.t = t + 1;
                        e.push_back(x);
                    end
                    phase = 1;
                    r     = t;
                end else if (phase == 1) begin
                    h     = (t - r < mx) ? t - r : mx;
                    phase = 2;
                end
            end
            prev = seg_lv[i];
            t    = t + seg_dur[i];
        end
    endtask

    task automatic compare_reports(input string tag, input rep_t e[$], input rep_t o[$]);
        int n;
        check_output({tag, "_count"}, o.size(), e.size());
        n = (o.size() < e.size()) ? o.size() : e.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_hi[%0d]", tag, i), o[i].hi, e[i].hi);
            check_output($sformatf("%s_per[%0d]", tag, i), o[i].per, e[i].per);
            check_output($sformatf("%s_ovf[%0d]", tag, i), o[i].ovf, e[i].ovf);
            check_output($sformatf("%s_to[%0d]", tag, i), o[i].to, e[i].to);
            if (i > 0) begin
                check_output($sformatf("%s_gap[%0d]", tag, i), o[i].t - o[i-1].t, e[i].t - e[i-1].t);
            end
        end
    endtask

    // Resets both DUTs, plays the segment list, then checks every report and that outputs hold afterwards.
    task automatic apply_stimulus(input string tag);
        rep_t e8[$];
        rep_t e9[$];
        @(negedge clk);
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        obs8.delete();
        obs9.delete();
        rst = 1'b0;
        for (int i = 0; i < seg_lv.size(); i++) begin
            pwm_in = seg_lv[i][0];
            repeat (seg_dur[i]) @(negedge clk);
        end
        repeat (SYNC + 3) @(negedge clk);
        build_model(255, e8);
        build_model(511, e9);
        compare_reports({tag, "_r8"}, e8, obs8);
        compare_reports({tag, "_r9"}, e9, obs9);
        if (e8.size() > 0) begin
            check_output({tag, "_hold_hi"}, int'(high_cnt8), e8[e8.size()-1].hi);
            check_output({tag, "_hold_per"}, int'(period8), e8[e8.size()-1].per);
        end
        seg_lv.delete();
        seg_dur.delete();
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clk);
        check_output("rst_high_cnt", int'(high_cnt8), 0);
        check_output("rst_period", int'(period8), 0);
        check_output("rst_valid", int'(valid8), 0);
        check_output("rst_ovf", int'(ovf8), 0);
        check_output("rst_timeout", int'(timeout8), 0);

        // 3 high / 5 low repeated
        add_seg(0, 4);
        for (int k = 0; k < 5; k++) begin
            add_seg(1, 3);
            add_seg(0, 5);
        end
        add_seg(1, 6);
        apply_stimulus("wave3_5");

        // 1-cycle pulse
        add_seg(0, 4);
        for (int k = 0; k < 4; k++) begin
            add_seg(1, 1);
            add_seg(0, 9);
        end
        add_seg(1, 6);
        apply_stimulus("wave1_9");

        // 256-cycle PWM at duty 64: saturates 8-bit build, fits 9-bit build
        add_seg(0, 4);
        for (int k = 0; k < 4; k++) begin
            add_seg(1, 64);
            add_seg(0, 192);
        end
        add_seg(1, 6);
        apply_stimulus("loop256");

        // high at reset release, then fall and rise
        add_seg(1, 10);
        add_seg(0, 7);
        add_seg(1, 3);
        add_seg(0, 4);
        add_seg(1, 6);
        apply_stimulus("high_at_release");

        // stuck low, then a recovered period to clear ovf
        add_seg(0, 4);
        add_seg(1, 5);
        add_seg(0, 400);
        add_seg(1, 4);
        add_seg(0, 6);
        add_seg(1, 6);
        apply_stimulus("stuck_low");

        // stuck high
        add_seg(0, 4);
        add_seg(1, 300);
        add_seg(0, 6);
        add_seg(1, 3);
        add_seg(0, 3);
        add_seg(1, 6);
        apply_stimulus("stuck_high");

        for (int run = 0; run < 3; run++) begin
            add_seg(0, 3);
            for (int k = 0; k < 6; k++) begin
                add_seg(1, int'($urandom_range(1, 20)));
                add_seg(0, int'($urandom_range(1, 30)));
            end
            add_seg(1, 6);
            apply_stimulus($sformatf("rand%0d", run));
        end

        // asynchronous reset in the middle of a high phase
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_output("midrst_high_cnt", int'(high_cnt8), 0);
        check_output("midrst_period", int'(period8), 0);
        check_output("midrst_valid", int'(valid8), 0);
        check_output("midrst_ovf", int'(ovf8), 0);
        check_output("midrst_timeout", int'(timeout8), 0);
        add_seg(1, 4);
        add_seg(0, 5);
        add_seg(1, 2);
        add_seg(0, 6);
        add_seg(1, 6);
        apply_stimulus("after_midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
